// File: rtl/arbitro_escrita_registradores_if.sv
// ---------------------------------------------------------------------------
// arbitro_escrita_registradores_if
//
// Bundle between the two writeback sources and the register-bank write port.
//
// Signals:
//   enable            - global grant enable (driven by the master side)
//   valid_0/reg_0/data_0, ready_0 - ALU writeback request and its grant
//   valid_1/reg_1/data_1, ready_1 - load writeback request and its grant
//   regWrite, write_register, write_data - registered bank write port
//   contention_count  - saturating count of contended cycles (CNT_W bits)
//
// Modports:
//   master - requester / environment side
//   slave  - the arbiter
// ---------------------------------------------------------------------------
interface arbitro_escrita_registradores_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             valid_0;
    logic [4:0]       reg_0;
    logic [31:0]      data_0;
    logic             ready_0;
    logic             valid_1;
    logic [4:0]       reg_1;
    logic [31:0]      data_1;
    logic             ready_1;
    logic             regWrite;
    logic [4:0]       write_register;
    logic [31:0]      write_data;
    logic [CNT_W-1:0] contention_count;

    modport master (
        output enable,
        output valid_0, reg_0, data_0,
        output valid_1, reg_1, data_1,
        input  ready_0, ready_1,
        input  regWrite, write_register, write_data,
        input  contention_count
    );

    modport slave (
        input  enable,
        input  valid_0, reg_0, data_0,
        input  valid_1, reg_1, data_1,
        output ready_0, ready_1,
        output regWrite, write_register, write_data,
        output contention_count
    );
endinterface

// File: rtl/arbitro_escrita_registradores.sv
// ---------------------------------------------------------------------------
// arbitro_escrita_registradores
//
// Round-robin arbiter for the single write port of the 32x32 register bank.
// Requester 0 is the ALU writeback, requester 1 the load writeback. Grants
// are combinational from valid/enable/priority; the bank write port
// (regWrite, write_register, write_data) is registered, giving one write
// pulse in the cycle after each accepted request.
//
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - arbitro_escrita_registradores_if.slave (requests, grants,
//             bank write port, contention counter)
//
// Parameters:
//   CNT_W   - width of the saturating contention counter
//
// Build option:
//   ARB_ZERO_REG_PROTECT_EN - when defined, transfers addressed to register 0
//             complete the handshake but never produce a bank write.
// ---------------------------------------------------------------------------
module arbitro_escrita_registradores #(
    parameter int CNT_W = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    arbitro_escrita_registradores_if.slave bus
);

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_e;

    prio_e            prio_q, prio_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       write_register_q, write_register_d;
    logic [31:0]      write_data_q, write_data_d;
    logic [CNT_W-1:0] contention_q, contention_d;

    logic             grant_0;
    logic             grant_1;
    logic             transfer;
    logic             commit;
    logic             contention;
    logic [4:0]       sel_reg;
    logic [31:0]      sel_data;

    // Grant depends only on valid, enable, reset and the priority pointer,
    // never on reg/data, so no data-to-ready combinational path exists.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // latch can be inferred on an unassigned path.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (reset_n && bus.enable) begin
            if (bus.valid_0 && bus.valid_1) begin
                grant_0 = (prio_q == PRIO_REQ0);
                grant_1 = (prio_q == PRIO_REQ1);
            end else begin
                grant_0 = bus.valid_0;
                grant_1 = bus.valid_1;
            end
        end
    end

    assign bus.ready_0 = grant_0;
    assign bus.ready_1 = grant_1;

    assign transfer   = grant_0 | grant_1;
    assign sel_reg    = grant_1 ? bus.reg_1  : bus.reg_0;
    assign sel_data   = grant_1 ? bus.data_1 : bus.data_0;
    assign contention = bus.valid_0 && bus.valid_1 && bus.enable;

`ifdef ARB_ZERO_REG_PROTECT_EN
    // Register 0 is hardwired: the handshake completes but the write is dropped.
    assign commit = transfer && (sel_reg != 5'd0);
`else
    assign commit = transfer;
`endif

    always_comb begin
        prio_d           = prio_q;
        reg_write_d      = commit;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        contention_d     = contention_q;

        // The requester that just transferred yields priority to the other.
        if (grant_0) begin
            prio_d = PRIO_REQ1;
        end else if (grant_1) begin
            prio_d = PRIO_REQ0;
        end

        if (commit) begin
            write_register_d = sel_reg;
            write_data_d     = sel_data;
        end

        // Saturate at all-ones instead of wrapping.
        if (contention && (contention_q != '1)) begin
            contention_d = contention_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q           <= PRIO_REQ0;
            reg_write_q      <= 1'b0;
            write_register_q <= 5'd0;
            write_data_q     <= 32'd0;
            contention_q     <= '0;
        end else begin
            prio_q           <= prio_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            contention_q     <= contention_d;
        end
    end

    assign bus.regWrite         = reg_write_q;
    assign bus.write_register   = write_register_q;
    assign bus.write_data       = write_data_q;
    assign bus.contention_count = contention_q;

endmodule

// File: doc/arbitro_escrita_registradores.md
# arbitro_escrita_registradores

Write-port arbiter for the 32x32 register bank. Two writeback sources share the bank's single write port: the ALU writeback (requester 0) and the load/memory writeback (requester 1). The block grants them round-robin with a valid/ready handshake and drives the bank's `regWrite`, `write_register` and `write_data` from registers, giving one clean write pulse per accepted request. It sits between the writeback stage and the register bank and also exposes a saturating contention counter for performance debug.

## Interface
- `CNT_W`, default 16: width of the contention counter.
- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: when 0, no new grants are issued; an already-registered write still completes.
- `valid_0`  in  1: ALU writeback request.
- `reg_0`  in  5: ALU destination register.
- `data_0`  in  32: ALU write data.
- `ready_0`  out  1: grant to requester 0 (combinational).
- `valid_1`  in  1: load writeback request.
- `reg_1`  in  5: load destination register.
- `data_1`  in  32: load write data.
- `ready_1`  out  1: grant to requester 1 (combinational).
- `regWrite`  out  1: registered write strobe to the bank.
- `write_register`  out  5: registered bank write address.
- `write_data`  out  32: registered bank write data.
- `contention_count`  out  CNT_W: saturating count of cycles in which both requesters were valid and `enable`=1.

## Operation
- Transfer on requester i is `valid_i && ready_i`. At most one transfer per cycle.
- Requesters hold `valid_i`, `reg_i` and `data_i` stable until the transfer. `valid` does not depend on `ready`.
- Grant logic, with `enable`=1 and `reset_n`=1:
  - Only one requester valid: that requester gets `ready`.
  - Both valid: the requester named by priority pointer `prio` gets `ready`.
  - `enable`=0: both `ready` are 0.
- `prio` state (1 bit): after a transfer by requester i, `prio` becomes 1-i. Without a transfer, `prio` is unchanged. Reset value of `prio` is 0.
- Output stage, on each clock:
  - `regWrite` <= transfer occurred.
  - On a transfer, `write_register` <= granted `reg_i` and `write_data` <= granted `data_i`.
  - Without a transfer, `write_register` and `write_data` hold their values.
- `contention_count` increments when `valid_0 && valid_1 && enable`. It saturates at all-ones; there is no wrap.
- Same destination register requested by both requesters in one cycle: no special handling. Round-robin order defines the write order, and the later write wins in the bank.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release) sets:
  - `regWrite`=0, `write_register`=0, `write_data`=0, `contention_count`=0, `prio`=0.
  - `ready_0`=`ready_1`=0 while `reset_n`=0.
- Latency: a transfer in cycle N gives `regWrite`=1 for exactly cycle N+1, carrying that transfer's address and data.
- Throughput: one write per cycle. Back-to-back transfers give `regWrite` held high with a new address and data each cycle.
- `ready` is combinational from `valid_*`, `enable` and `prio`. There is no combinational path from `data_*` or `reg_*` to `ready`.
- Reset asserted mid-operation: any registered, not-yet-presented write is discarded, and `regWrite` drops immediately. Requesters must re-present.
- `enable` deasserted in the same cycle as a request: no grant. `regWrite` from the previous cycle's transfer still fires.

## Configuration
- `ARB_ZERO_REG_PROTECT_EN`
  - Defined: a transfer with `reg_i`=0 is accepted (handshake completes, `prio` advances), but `regWrite` stays 0 in the next cycle and `write_register`/`write_data` are not updated. Register 0 is therefore never written.
  - Undefined: register 0 is written like any other register.

## Test plan
- Reset, then `valid_0`=1, `reg_0`=5, `data_0`=0x1234, `valid_1`=0 → `ready_0`=1 in the same cycle. The next cycle shows `regWrite`=1, `write_register`=5, `write_data`=0x1234. The cycle after shows `regWrite`=0.
- Both valid continuously for 4 cycles with `enable`=1, after reset → grants go 0,1,0,1. `regWrite` is high for 4 consecutive cycles. `contention_count`=4.
- Both valid, same `reg`=7, `data_0`=0xA, `data_1`=0xB, `prio`=0 → write 0xA then 0xB to register 7 on consecutive cycles.
- `enable`=0 with both valid for 3 cycles → no `ready`, `regWrite`=0, `contention_count` unchanged. Raising `enable` grants the requester named by `prio`.
- Assert `reset_n`=0 in the cycle after a transfer → `regWrite` drops asynchronously. After release, all outputs are 0 and `prio`=0.
- With `ARB_ZERO_REG_PROTECT_EN`: `valid_1`=1, `reg_1`=0, `data_1`=0xFF → `ready_1`=1, `regWrite` stays 0, and `prio` advances to 0. Without the macro, the same stimulus gives `regWrite`=1 with `write_register`=0 and `write_data`=0xFF.
